serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Parametrised, clocked successor to the combinational half adder.
- Adds two WIDTH-bit operands plus a carry-in bit-serially, LSB first, through one full-adder stage and a carry flip-flop.
- Uses a start/busy/done handshake and produces registered Sum, Carry and signed Overflow.
- Building block for area-constrained arithmetic datapaths in the team's designs.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; sampled on the edge that accepts start.
- B  input  WIDTH  operand B; sampled on the edge that accepts start.
- Cin  input  1  carry-in; sampled on the edge that accepts start.
- Sum  output  WIDTH  registered result, A+B+Cin mod 2^WIDTH.
- Carry  output  1  registered unsigned carry-out.
- Overflow  output  1  registered signed overflow (two's complement).
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when Sum/Carry/Overflow are updated.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; Sum=0, Carry=0, Overflow=0, busy=0, done=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Reset overrides start. Reset during RUN aborts the operation with no done pulse; outputs go to 0.
- FSM states: IDLE, RUN. busy = (state==RUN), decoded combinationally from the state register.
- IDLE, start=1 at edge E:
  - Load a_sh<=A, b_sh<=B, c<=Cin, cnt<=0; state<=RUN.
  - start=0 keeps IDLE with outputs held.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^c.
  - Shift s into the MSB of the internal sum register (shift right).
  - c <= majority(a_sh[0], b_sh[0], c).
  - a_sh and b_sh shift right; cnt++.
  - Counter width is clog2(WIDTH)+1 so that WIDTH=1 is legal.
- Final bit (cnt==WIDTH-1), edge E+WIDTH:
  - Sum <= completed sum, including this cycle's bit.
  - Carry <= carry-out of the MSB.
  - Overflow <= (carry into MSB) XOR (carry-out of MSB).
  - done <= 1; state <= IDLE.
- Latency: done is high in the cycle after edge E+WIDTH, i.e. WIDTH cycles after the accepting edge. Throughput is one addition per WIDTH cycles.
- done is high for exactly one cycle. Sum/Carry/Overflow hold their values until the next completion or reset; they never show partial results.
- start while busy is ignored. No queuing; A/B/Cin changes are ignored.
- start high during the done cycle (state already IDLE) is accepted: back-to-back operation with no gap cycle.
- Result wraps modulo 2^WIDTH; Carry holds bit WIDTH of the true sum.

Test Plan:
- WIDTH=1, Cin=0, sweep A,B over 00/01/10/11 -> Sum,Carry = 0,0 / 1,0 / 1,0 / 0,1. Each done arrives 1 cycle after start (half-adder truth table regression).
- WIDTH=8: 8'h0F+8'h01, Cin=0 -> Sum=8'h10, Carry=0, Overflow=0. done exactly 8 cycles after the accepting edge; busy high for those 8 cycles.
- WIDTH=8 boundaries:
  - 8'hFF+8'h01 -> Sum=8'h00, Carry=1, Overflow=0.
  - 8'h7F+8'h01 -> Sum=8'h80, Carry=0, Overflow=1.
  - 8'hFF+8'hFF, Cin=1 -> Sum=8'hFF, Carry=1, Overflow=0.
- Handshake:
  - start re-pulsed with different operands mid-RUN -> ignored, original result returned.
  - start held high on the done cycle with 8'h01+8'h02 -> second done 8 cycles later, Sum=8'h03.
- rst asserted at cycle 4 of a RUN -> next cycle busy=0, done=0, Sum=0, Carry=0, Overflow=0, and no done pulse follows. A fresh start then completes normally.
- Random WIDTH=16 and WIDTH=64 operands/Cin, 1000 iterations -> {Carry,Sum} == A+B+Cin. Overflow matches the signed reference model.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: computes A + B + Cin over WIDTH clock cycles, LSB
//   first, using one full-adder stage and a carry flop. Results appear only
//   on completion and hold until the next completion or reset.
//
// Parameters
//   WIDTH     operand / sum width in bits (1..64)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     begin an addition (accepted only while idle)
//   A, B      operands, captured on the accepting edge
//   Cin       carry-in, captured on the accepting edge
//   Sum       registered sum, A+B+Cin mod 2^WIDTH
//   Carry     registered unsigned carry-out
//   Overflow  registered two's-complement overflow
//   busy      high while an addition is in progress
//   done      one-cycle pulse when Sum/Carry/Overflow update
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow,
    output logic             busy,
    output logic             done
);

    // One extra counter bit keeps the counter non-zero width when WIDTH=1.
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] sum_next;
    logic             c;
    logic             bit_s;
    logic             bit_c;
    logic [CW-1:0]    cnt;

    // Full-adder stage on the current LSBs; the new sum bit enters at the
    // MSB so that after WIDTH shifts the register holds the sum in order.
    always_comb begin
        bit_s    = a_sh[0] ^ b_sh[0] ^ c;
        bit_c    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        sum_next = s_sh >> 1;
        sum_next[WIDTH-1] = bit_s;
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            s_sh     <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        c     <= Cin;
                        s_sh  <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= sum_next;
                    c    <= bit_c;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // On the MSB, c is the carry into the MSB and bit_c
                        // the carry out of it.
                        Sum      <= sum_next;
                        Carry    <= bit_c;
                        Overflow <= c ^ bit_c;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed checks of serial_adder at WIDTH=1 and WIDTH=8, plus randomised
//   checks at WIDTH=16 and WIDTH=64 against a full-width arithmetic model.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // WIDTH=1 instance
    logic       st1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, s1;
    logic       ci1 = 1'b0, co1, ov1, busy1, done1;

    // WIDTH=8 instance
    logic       st8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic       ci8 = 1'b0, co8, ov8, busy8, done8;

    // WIDTH=16 instance
    logic        st16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, s16;
    logic        ci16 = 1'b0, co16, ov16, busy16, done16;

    // WIDTH=64 instance
    logic        st64 = 1'b0;
    logic [63:0] a64 = '0, b64 = '0, s64;
    logic        ci64 = 1'b0, co64, ov64, busy64, done64;

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1), .Cin(ci1),
        .Sum(s1), .Carry(co1), .Overflow(ov1), .busy(busy1), .done(done1)
    );
    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .Cin(ci8),
        .Sum(s8), .Carry(co8), .Overflow(ov8), .busy(busy8), .done(done8)
    );
    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .A(a16), .B(b16), .Cin(ci16),
        .Sum(s16), .Carry(co16), .Overflow(ov16), .busy(busy16), .done(done16)
    );
    serial_adder #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .start(st64), .A(a64), .B(b64), .Cin(ci64),
        .Sum(s64), .Carry(co64), .Overflow(ov64), .busy(busy64), .done(done64)
    );

    // Counts edges after the accepting edge until done8 is seen (sampled
    // 1 time unit after each edge); -1 if the limit expires.
    task automatic wait_done8(input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                cycles = k;
                return;
            end
        end
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(negedge clk);
        a8 = a; b8 = b; ci8 = ci; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({s8, co8, ov8, busy8, done8} !== 12'h000) begin
            failures++;
            $display("FAIL reset_w8: got sum=%h c=%b ov=%b busy=%b done=%b, expected all 0",
                     s8, co8, ov8, busy8, done8);
        end
        checks++;
        if ({s1, co1, ov1, busy1, done1} !== 5'b0) begin
            failures++;
            $display("FAIL reset_w1: got %b%b%b%b%b, expected 00000", s1, co1, ov1, busy1, done1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_half_adder;
        logic [1:0] ab;
        logic [2:0] expv [4];
        int cyc;
        // {Sum, Carry, Overflow} for A,B = 00, 01, 10, 11 with Cin=0
        expv[0] = 3'b000; expv[1] = 3'b100; expv[2] = 3'b100; expv[3] = 3'b011;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            @(negedge clk);
            a1 = ab[1]; b1 = ab[0]; ci1 = 1'b0; st1 = 1'b1;
            @(posedge clk); #1;
            st1 = 1'b0;
            cyc = -1;
            for (int k = 1; k <= 4; k++) begin
                @(posedge clk); #1;
                if (done1) begin cyc = k; break; end
            end
            checks++;
            if (cyc != 1) begin
                failures++;
                $display("FAIL w1_latency ab=%b: got %0d cycles, expected 1", ab, cyc);
            end
            checks++;
            if ({s1, co1, ov1} !== expv[i]) begin
                failures++;
                $display("FAIL w1_result ab=%b: got s/c/ov=%b, expected %b", ab, {s1, co1, ov1}, expv[i]);
            end
        end
    endtask

    task automatic test_basic8;
        int busy_bad = 0;
        int done_at = -1;
        start8(8'h0F, 8'h01, 1'b0);
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_accept: got %b, expected 1", busy8);
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k < 8 && (busy8 !== 1'b1 || done8 !== 1'b0)) busy_bad++;
            if (done8 && done_at < 0) done_at = k;
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL basic_busy_window: %0d bad cycles, expected 0", busy_bad);
        end
        checks++;
        if (done_at != 8) begin
            failures++;
            $display("FAIL basic_latency: got done at %0d, expected 8", done_at);
        end
        checks++;
        if ({s8, co8, ov8} !== {8'h10, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL basic_result: got sum=%h c=%b ov=%b, expected 10/0/0", s8, co8, ov8);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle_after: got busy=%b done=%b, expected 0/0", busy8, done8);
        end
    endtask

    task automatic test_boundaries8;
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        logic [9:0] te [3];   // {Sum, Carry, Overflow}
        int cyc;
        ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0; te[0] = {8'h00, 1'b1, 1'b0};
        ta[1] = 8'h7F; tb[1] = 8'h01; tc[1] = 1'b0; te[1] = {8'h80, 1'b0, 1'b1};
        ta[2] = 8'hFF; tb[2] = 8'hFF; tc[2] = 1'b1; te[2] = {8'hFF, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            start8(ta[i], tb[i], tc[i]);
            wait_done8(12, cyc);
            checks++;
            if (cyc != 8) begin
                failures++;
                $display("FAIL boundary_latency[%0d]: got %0d, expected 8", i, cyc);
            end
            checks++;
            if ({s8, co8, ov8} !== te[i]) begin
                failures++;
                $display("FAIL boundary_result[%0d]: got sum=%h c=%b ov=%b, expected sum=%h c=%b ov=%b",
                         i, s8, co8, ov8, te[i][9:2], te[i][1], te[i][0]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int cyc;
        start8(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        // Three edges have passed since acceptance; five more to done.
        wait_done8(10, cyc);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL ignore_latency: got %0d remaining, expected 5", cyc);
        end
        checks++;
        if ({s8, co8, ov8} !== {8'h46, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL ignore_result: got sum=%h c=%b ov=%b, expected 46/0/0", s8, co8, ov8);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        start8(8'h40, 8'h40, 1'b0);
        wait_done8(12, cyc);
        // Now in the done cycle: request the next addition immediately.
        a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; st8 = 1'b1;
        checks++;
        if ({s8, co8, ov8, done8} !== {8'h80, 1'b0, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL b2b_first: got sum=%h c=%b ov=%b done=%b, expected 80/0/1/1",
                     s8, co8, ov8, done8);
        end
        @(posedge clk); #1;
        st8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: busy got %b, expected 1", busy8);
        end
        wait_done8(12, cyc);
        checks++;
        if (cyc != 8) begin
            failures++;
            $display("FAIL b2b_latency: got %0d, expected 8", cyc);
        end
        checks++;
        if ({s8, co8, ov8} !== {8'h03, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second: got sum=%h c=%b ov=%b, expected 03/0/0", s8, co8, ov8);
        end
    endtask

    task automatic test_reset_mid_run;
        int seen = 0;
        int cyc;
        start8(8'h55, 8'h22, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({s8, co8, ov8, busy8, done8} !== 12'h000) begin
            failures++;
            $display("FAIL midrun_reset: got sum=%h c=%b ov=%b busy=%b done=%b, expected all 0",
                     s8, co8, ov8, busy8, done8);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrun_no_done: got %0d active cycles, expected 0", seen);
        end
        start8(8'h20, 8'h22, 1'b0);
        wait_done8(12, cyc);
        checks++;
        if (cyc != 8 || s8 !== 8'h42 || co8 !== 1'b0) begin
            failures++;
            $display("FAIL midrun_restart: got cycles=%0d sum=%h c=%b, expected 8/42/0", cyc, s8, co8);
        end
    endtask

    task automatic test_random;
        fork
            begin
                logic [16:0] ref16;
                logic        ovr16;
                int          got;
                for (int n = 0; n < 1000; n++) begin
                    @(negedge clk);
                    a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
                    st16 = 1'b1;
                    @(posedge clk); #1;
                    st16 = 1'b0;
                    got = 0;
                    for (int k = 0; k < 20; k++) begin
                        @(posedge clk); #1;
                        if (done16) begin got = 1; break; end
                    end
                    ref16 = {1'b0, a16} + {1'b0, b16} + 17'(ci16);
                    ovr16 = (a16[15] == b16[15]) && (ref16[15] != a16[15]);
                    checks++;
                    if (got == 0 || {co16, s16} !== ref16 || ov16 !== ovr16) begin
                        failures++;
                        $display("FAIL rand16 %h+%h+%b: got done=%0d c=%b sum=%h ov=%b, expected c=%b sum=%h ov=%b",
                                 a16, b16, ci16, got, co16, s16, ov16, ref16[16], ref16[15:0], ovr16);
                    end
                end
            end
            begin
                logic [64:0] ref64;
                logic        ovr64;
                int          got;
                for (int n = 0; n < 1000; n++) begin
                    @(negedge clk);
                    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; ci64 = 1'($urandom);
                    st64 = 1'b1;
                    @(posedge clk); #1;
                    st64 = 1'b0;
                    got = 0;
                    for (int k = 0; k < 70; k++) begin
                        @(posedge clk); #1;
                        if (done64) begin got = 1; break; end
                    end
                    ref64 = {1'b0, a64} + {1'b0, b64} + 65'(ci64);
                    ovr64 = (a64[63] == b64[63]) && (ref64[63] != a64[63]);
                    checks++;
                    if (got == 0 || {co64, s64} !== ref64 || ov64 !== ovr64) begin
                        failures++;
                        $display("FAIL rand64 %h+%h+%b: got done=%0d c=%b sum=%h ov=%b, expected c=%b sum=%h ov=%b",
                                 a64, b64, ci64, got, co64, s64, ov64, ref64[64], ref64[63:0], ovr64);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset;
        test_half_adder;
        test_basic8;
        test_boundaries8;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_run;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
